key_note_controller: RTL

Parametrised keyboard front end for the piano datapath. Synchronises and debounces NUM_KEYS raw key inputs, resolves them into a single active note index (0 = silence, key i maps to note i+1), and drives a matching one-hot light vector. It supports momentary and latch play modes, and emits note-on/note-off events through a small FIFO with a valid/ready handshake to the tone generator and recorder.

---
 rtl/key_note_controller_if.sv | 17 +
 rtl/key_note_controller.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/key_note_controller_if.sv
// Event channel from the key front end to the tone generator / recorder.
// master: producer (key_note_controller); slave: consumer.
//   evt_valid  head entry present
//   evt_ready  consumer takes head entry when evt_valid & evt_ready
//   evt_note   head entry note (0 when empty)
//   evt_on     head entry type, 1 = note-on, 0 = note-off (0 when empty)
interface key_note_controller_if #(
  parameter int NOTE_W = 4
);
  logic              evt_valid;
  logic              evt_ready;
  logic [NOTE_W-1:0] evt_note;
  logic              evt_on;

  modport master (output evt_valid, evt_note, evt_on, input evt_ready);
  modport slave  (input evt_valid, evt_note, evt_on, output evt_ready);
endinterface

// File: rtl/key_note_controller.sv
// Keyboard front end: per-key sync + debounce, note resolution (momentary or
// latch), one-hot light, and a small note-on/off event FIFO.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   keys         raw key levels (async), 1 = pressed
//   mode         0 = momentary, 1 = latch
//   note         registered active note, 0 = none
//   light        registered one-hot of active key
//   evt_ovf      sticky overflow, cleared only by reset
//   evt          event channel (master side)

// One key: two-flop synchroniser, debounce counter, accepted level and its
// 0->1 edge (stable now, not stable the cycle before).
module key_note_lane #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          s1, s2, stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_d <= stable;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = stable & ~stable_d;
endmodule

module key_note_controller #(
  parameter int NUM_KEYS        = 7,
  parameter int NOTE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_KEYS-1:0]   keys,
  input  logic                  mode,
  output logic [NOTE_W-1:0]     note,
  output logic [NUM_KEYS-1:0]   light,
  output logic                  evt_ovf,
  key_note_controller_if.master evt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic              on;
  } evt_t;

  logic [NUM_KEYS-1:0] stable, rise;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
    key_note_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (keys[g]),
      .stable (stable[g]),
      .rise   (rise[g])
    );
  end

  // ---------------- note resolution ----------------
  logic                mode_q;
  logic [NOTE_W-1:0]   lo_st, lo_rs, next_note, note_prev;
  logic [NUM_KEYS-1:0] light_n;

  always_comb begin
    lo_st = '0;
    lo_rs = '0;
    // Walk downward so the lowest index is the last one written.
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (stable[i]) lo_st = NOTE_W'(i + 1);
      if (rise[i])   lo_rs = NOTE_W'(i + 1);
    end
    next_note = note;
    if (mode != mode_q)     next_note = '0;
    else if (!mode)         next_note = lo_st;
    else if (lo_rs != '0)   next_note = (lo_rs == note) ? '0 : lo_rs;
    for (int i = 0; i < NUM_KEYS; i++) light_n[i] = (next_note == NOTE_W'(i + 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 1'b0;
      note      <= '0;
      note_prev <= '0;
      light     <= '0;
    end else begin
      mode_q    <= mode;
      note      <= next_note;
      note_prev <= note;
      light     <= light_n;
    end
  end

  // ---------------- event FIFO ----------------
  // A note change seen between note_prev and note is pushed one cycle after
  // note itself updates; both entries of a change go in together or not at all.
  evt_t            mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, wr_on;
  logic [CW-1:0]   count, need, free_slots;
  logic            need_off, need_on, accept, pop;

  assign need_off   = (note != note_prev) && (note_prev != '0);
  assign need_on    = (note != note_prev) && (note != '0);
  assign need       = CW'(need_off) + CW'(need_on);
  assign free_slots = CW'(FIFO_DEPTH) - count;   // pre-pop occupancy
  assign accept     = (need <= free_slots);
  assign pop        = (count != '0) && evt.evt_ready;
  assign wr_on      = wr_ptr + PW'(need_off);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      evt_ovf <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(need);
      else        evt_ovf <= 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count <= count + (accept ? need : CW'(0)) - CW'(pop);
    end
  end

  // Storage needs no reset: emptiness is carried by count and outputs are masked.
  always_ff @(posedge clk) begin
    if (accept && need_off) mem[wr_ptr] <= evt_t'{note: note_prev, on: 1'b0};
    if (accept && need_on)  mem[wr_on]  <= evt_t'{note: note,      on: 1'b1};
  end

  assign evt.evt_valid = (count != '0);
  assign evt.evt_note  = evt.evt_valid ? mem[rd_ptr].note : '0;
  assign evt.evt_on    = evt.evt_valid ? mem[rd_ptr].on   : 1'b0;
endmodule
